// File: rtl/jk_bank_ctrl.sv
// rtl/jk_bank_ctrl.sv - command sequencer driving the j/k inputs of a WIDTH-bit JK flip-flop bank
// Optional shadow-versus-bank consistency check is enabled by defining JK_CTRL_CHECK_EN.
module jk_bank_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_len,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             err
);
   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_COUNT} state_t;

   localparam logic [2:0] OP_CLR  = 3'd1;
   localparam logic [2:0] OP_SET  = 3'd2;
   localparam logic [2:0] OP_LOAD = 3'd3;
   localparam logic [2:0] OP_TGL  = 3'd4;
   localparam logic [2:0] OP_UP   = 3'd5;
   localparam logic [2:0] OP_DN   = 3'd6;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_j, r_k, w_j_nxt, w_k_nxt;
   logic [WIDTH-1:0] r_shadow, w_shadow_nxt, w_up_pat, w_dn_pat;
   logic             r_shadow_valid, w_shadow_valid_nxt;
   logic [2:0]       r_op, w_op_nxt;
   logic [CNT_W-1:0] r_remain, w_remain_nxt;
   logic             r_done, w_done_nxt;

   // Shadow follows the bank: it captures the same j/k on the same edge.
   assign w_shadow_nxt = (r_j & ~r_shadow) | (~r_k & r_shadow);

   // Count patterns are derived from the state the bank will hold after this edge.
   always_comb begin
      w_up_pat    = '0;
      w_dn_pat    = '0;
      w_up_pat[0] = 1'b1;
      w_dn_pat[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         w_up_pat[i] = w_up_pat[i-1] &  w_shadow_nxt[i-1];
         w_dn_pat[i] = w_dn_pat[i-1] & ~w_shadow_nxt[i-1];
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_j_nxt            = '0;
      w_k_nxt            = '0;
      w_op_nxt           = r_op;
      w_remain_nxt       = r_remain;
      w_done_nxt         = 1'b0;
      w_shadow_valid_nxt = r_shadow_valid;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_op_nxt     = cmd_op;
               w_remain_nxt = cmd_len;
               if ((cmd_op == OP_UP || cmd_op == OP_DN) && cmd_len != '0) begin
                  w_state_nxt = S_COUNT;
                  w_j_nxt     = (cmd_op == OP_UP) ? w_up_pat : w_dn_pat;
                  w_k_nxt     = (cmd_op == OP_UP) ? w_up_pat : w_dn_pat;
               end else begin
                  w_state_nxt = S_APPLY;
                  case (cmd_op)
                     OP_CLR:  w_k_nxt = '1;
                     OP_SET:  w_j_nxt = '1;
                     OP_LOAD: begin
                        w_j_nxt = cmd_data;
                        w_k_nxt = ~cmd_data;
                     end
                     OP_TGL: begin
                        w_j_nxt = cmd_data;
                        w_k_nxt = cmd_data;
                     end
                     default: ;
                  endcase
               end
            end
         end
         S_APPLY: begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            if (r_op == OP_CLR || r_op == OP_SET || r_op == OP_LOAD)
               w_shadow_valid_nxt = 1'b1;
         end
         S_COUNT: begin
            if (r_remain == CNT_W'(1)) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_remain_nxt = r_remain - CNT_W'(1);
               w_j_nxt      = (r_op == OP_UP) ? w_up_pat : w_dn_pat;
               w_k_nxt      = (r_op == OP_UP) ? w_up_pat : w_dn_pat;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_j            <= '0;
         r_k            <= '0;
         r_shadow       <= '0;
         r_shadow_valid <= 1'b0;
         r_op           <= '0;
         r_remain       <= '0;
         r_done         <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_j            <= w_j_nxt;
         r_k            <= w_k_nxt;
         r_shadow       <= w_shadow_nxt;
         r_shadow_valid <= w_shadow_valid_nxt;
         r_op           <= w_op_nxt;
         r_remain       <= w_remain_nxt;
         r_done         <= w_done_nxt;
      end
   end

   assign j         = r_j;
   assign k         = r_k;
   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;

`ifdef JK_CTRL_CHECK_EN
   logic r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_err <= 1'b0;
      else if (r_shadow_valid && (q != r_shadow))
         r_err <= 1'b1;
   end

   assign err = r_err;
`else
   logic w_unused_q;

   assign w_unused_q = ^q;
   assign err        = 1'b0;
`endif
endmodule
